// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: operation encodings and the
// default operand/accumulator widths used by the filter top.
package fir_pkg;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_MAC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 38;

endpackage

// File: rtl/sat_add.sv
// W-bit signed adder with overflow detection; with SAT=1 an overflowing
// result clamps to the W-bit signed range, otherwise it wraps.
module sat_add #(
    parameter int W   = 38,
    parameter bit SAT = 1'b1
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};
    assign ovf  = wide[W] ^ wide[W-1];

    // The extra top bit is the true sign, so it picks the clamp direction.
    always_comb begin
        sum = wide[W-1:0];
        if (SAT && ovf) begin
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fir_mac_alu.sv
// Two-stage pipelined signed MUL/ADD/MAC/LOAD unit with an internal
// accumulator and sticky overflow flag for the FIR datapath.
module fir_mac_alu
    import fir_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter bit SAT = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 IN_VALID,
    input  logic signed [DW-1:0] A,
    input  logic signed [DW-1:0] B,
    input  logic [1:0]           MODE,
    output logic                 OUT_VALID,
    output logic signed [AW-1:0] ANS,
    output logic signed [AW-1:0] ACC,
    output logic                 OVF
);

    generate
        if (AW < 2*DW+1) begin : g_aw_check
            $error("fir_mac_alu: AW must be at least 2*DW+1");
        end
    endgenerate

    logic signed [2*DW-1:0] p1;
    logic signed [AW-1:0]   s1;
    mode_e                  mode1;
    logic                   v1;

    // Operand registers only load on valid cycles so idle-cycle X never enters.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            p1    <= '0;
            s1    <= '0;
            mode1 <= MODE_MUL;
            v1    <= 1'b0;
        end else begin
            v1 <= IN_VALID;
            if (IN_VALID) begin
                p1    <= (2*DW)'(A) * (2*DW)'(B);
                s1    <= AW'(A) + AW'(B);
                mode1 <= mode_e'(MODE);
            end
        end
    end

    logic signed [AW-1:0] p1_ext;
    logic signed [AW-1:0] mac_sum;
    logic                 mac_ovf;
    logic signed [AW-1:0] ans_d;
    logic signed [AW-1:0] acc_d;
    logic                 ovf_d;

    assign p1_ext = AW'(p1);

    sat_add #(
        .W   (AW),
        .SAT (SAT)
    ) u_sat_add (
        .a   (ACC),
        .b   (p1_ext),
        .sum (mac_sum),
        .ovf (mac_ovf)
    );

    always_comb begin
        ans_d = ANS;
        acc_d = ACC;
        ovf_d = OVF;
        if (v1) begin
            case (mode1)
                MODE_MUL:  ans_d = p1_ext;
                MODE_ADD:  ans_d = s1;
                MODE_MAC: begin
                    ans_d = mac_sum;
                    acc_d = mac_sum;
                    ovf_d = OVF | mac_ovf;
                end
                MODE_LOAD: begin
                    ans_d = p1_ext;
                    acc_d = p1_ext;
                    ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            OUT_VALID <= 1'b0;
            ANS       <= '0;
            ACC       <= '0;
            OVF       <= 1'b0;
        end else begin
            OUT_VALID <= v1;
            ANS       <= ans_d;
            ACC       <= acc_d;
            OVF       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_alu.sv
// Directed-vector bench for fir_mac_alu: default widths plus two AW=33
// instances (saturating and wrapping) driven with the same stimulus.
module tb_fir_mac_alu;

    localparam logic [1:0] M_MUL  = 2'b00;
    localparam logic [1:0] M_ADD  = 2'b01;
    localparam logic [1:0] M_MAC  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic                CLK;
    logic                RESETN;
    logic                IN_VALID;
    logic signed [15:0]  A;
    logic signed [15:0]  B;
    logic [1:0]          MODE;

    logic                ov_m, ov_s, ov_w;
    logic signed [37:0]  ans_m, acc_m;
    logic signed [32:0]  ans_s, acc_s, ans_w, acc_w;
    logic                ovf_m, ovf_s, ovf_w;

    int vectors    = 0;
    int miscompares = 0;

    fir_mac_alu #(.DW(16), .AW(38), .SAT(1'b1)) dut (
        .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .A(A), .B(B), .MODE(MODE),
        .OUT_VALID(ov_m), .ANS(ans_m), .ACC(acc_m), .OVF(ovf_m)
    );

    fir_mac_alu #(.DW(16), .AW(33), .SAT(1'b1)) dut_sat (
        .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .A(A), .B(B), .MODE(MODE),
        .OUT_VALID(ov_s), .ANS(ans_s), .ACC(acc_s), .OVF(ovf_s)
    );

    fir_mac_alu #(.DW(16), .AW(33), .SAT(1'b0)) dut_wrap (
        .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .A(A), .B(B), .MODE(MODE),
        .OUT_VALID(ov_w), .ANS(ans_w), .ACC(acc_w), .OVF(ovf_w)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic signed [63:0] got,
                               input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs; returns #1 after the edge that captured them.
    task automatic applyStimulus(input logic v, input logic signed [15:0] a,
                                 input logic signed [15:0] b, input logic [1:0] m);
        IN_VALID = v;
        A        = a;
        B        = b;
        MODE     = m;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESETN   = 1'b0;
        IN_VALID = 1'b0;
        A        = '0;
        B        = '0;
        MODE     = M_MUL;
        #12;
        checkOutput("rst_ans", ans_m, 0);
        checkOutput("rst_acc", acc_m, 0);
        checkOutput("rst_ovf", ovf_m, 0);
        checkOutput("rst_ov",  ov_m, 0);
        checkOutput("rst_ov_sat",  ov_s, 0);
        checkOutput("rst_ov_wrap", ov_w, 0);
        @(negedge CLK);
        RESETN = 1'b1;

        // MUL then ADD
        applyStimulus(1'b1, -16'sd3, 16'sd7, M_MUL);
        applyStimulus(1'b1, 16'sd32767, 16'sd32767, M_ADD);
        checkOutput("mul_ans", ans_m, -21);
        checkOutput("mul_ov",  ov_m, 1);
        checkOutput("mul_acc", acc_m, 0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, M_MUL);
        checkOutput("add_ans", ans_m, 65534);
        checkOutput("add_ov",  ov_m, 1);
        checkOutput("add_acc", acc_m, 0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, M_MUL);
        checkOutput("idle_ov",  ov_m, 0);
        checkOutput("idle_ans", ans_m, 65534);

        // LOAD + MAC tap sequence
        applyStimulus(1'b1, 16'sd2, 16'sd3, M_LOAD);
        applyStimulus(1'b1, 16'sd4, 16'sd5, M_MAC);
        checkOutput("load_ans", ans_m, 6);
        checkOutput("load_acc", acc_m, 6);
        applyStimulus(1'b1, -16'sd1, 16'sd6, M_MAC);
        checkOutput("mac1_ans", ans_m, 26);
        applyStimulus(1'b0, 16'sd0, 16'sd0, M_MUL);
        checkOutput("mac2_ans", ans_m, 20);
        checkOutput("mac2_acc", acc_m, 20);
        checkOutput("mac2_ovf", ovf_m, 0);

        // MUL between LOAD and MAC leaves ACC alone
        applyStimulus(1'b1, 16'sd10, 16'sd1, M_LOAD);
        applyStimulus(1'b1, 16'sd2, 16'sd2, M_MUL);
        checkOutput("il_load_ans", ans_m, 10);
        applyStimulus(1'b1, 16'sd1, 16'sd1, M_MAC);
        checkOutput("il_mul_ans", ans_m, 4);
        checkOutput("il_mul_acc", acc_m, 10);
        applyStimulus(1'b0, 16'sd0, 16'sd0, M_MUL);
        checkOutput("il_mac_ans", ans_m, 11);
        checkOutput("il_mac_acc", acc_m, 11);

        // Valid gap with garbage operands on the idle cycle
        applyStimulus(1'b1, 16'sd0, 16'sd0, M_LOAD);
        applyStimulus(1'b1, 16'sd1, 16'sd1, M_MAC);
        checkOutput("gap_zero_acc", acc_m, 0);
        applyStimulus(1'b0, 'x, 'x, 'x);
        checkOutput("gap1_ov",  ov_m, 1);
        checkOutput("gap1_acc", acc_m, 1);
        applyStimulus(1'b1, 16'sd1, 16'sd1, M_MAC);
        checkOutput("gap0_ov",  ov_m, 0);
        checkOutput("gap0_ans", ans_m, 1);
        checkOutput("gap0_acc", acc_m, 1);
        applyStimulus(1'b0, 16'sd0, 16'sd0, M_MUL);
        checkOutput("gap2_ov",  ov_m, 1);
        checkOutput("gap2_acc", acc_m, 2);
        checkOutput("gap2_ans", ans_m, 2);

        // Saturation / wrap on the AW=33 instances
        applyStimulus(1'b1, -16'sd32768, -16'sd32768, M_LOAD);
        applyStimulus(1'b1, -16'sd32768, -16'sd32768, M_MAC);
        checkOutput("sat_load_acc", acc_s, 64'sd1073741824);
        applyStimulus(1'b1, -16'sd32768, -16'sd32768, M_MAC);
        checkOutput("sat_mac1_acc", acc_s, 64'sd2147483648);
        applyStimulus(1'b1, -16'sd32768, -16'sd32768, M_MAC);
        checkOutput("sat_mac2_acc", acc_s, 64'sd3221225472);
        checkOutput("sat_mac2_ovf", ovf_s, 0);
        applyStimulus(1'b1, 16'sd1, 16'sd1, M_LOAD);
        checkOutput("sat_clamp_acc", acc_s, 64'sd4294967295);
        checkOutput("sat_clamp_ans", ans_s, 64'sd4294967295);
        checkOutput("sat_clamp_ovf", ovf_s, 1);
        checkOutput("wrap_acc",      acc_w, -64'sd4294967296);
        checkOutput("wrap_ovf",      ovf_w, 1);
        checkOutput("wide_acc",      acc_m, 64'sd4294967296);
        checkOutput("wide_ovf",      ovf_m, 0);
        applyStimulus(1'b0, 16'sd0, 16'sd0, M_MUL);
        checkOutput("sat_reload_acc",  acc_s, 1);
        checkOutput("sat_reload_ovf",  ovf_s, 0);
        checkOutput("wrap_reload_acc", acc_w, 1);
        checkOutput("wrap_reload_ovf", ovf_w, 0);

        // Asynchronous reset with both stages occupied
        applyStimulus(1'b1, 16'sd3, 16'sd3, M_MAC);
        applyStimulus(1'b1, 16'sd3, 16'sd3, M_MAC);
        #2;
        RESETN = 1'b0;
        #1;
        checkOutput("arst_ans", ans_m, 0);
        checkOutput("arst_acc", acc_m, 0);
        checkOutput("arst_ovf", ovf_m, 0);
        checkOutput("arst_ov",  ov_m, 0);
        IN_VALID = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("arst_post1_ov", ov_m, 0);
        @(posedge CLK);
        #1;
        checkOutput("arst_post2_ov",  ov_m, 0);
        checkOutput("arst_post2_acc", acc_m, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_mac_alu.md
Name: fir_mac_alu

Overview:
Parametrised, pipelined signed arithmetic unit for the FIR datapath; the successor to the two-mode multiply/add ALU. It adds a valid-qualified 2-stage pipeline, an internal accumulator for multiply-accumulate over filter taps, and optional saturation with a sticky overflow flag. It sits between the coefficient/sample memories and the filter output register.

Parameters:
DW, 16, signed width of operands A and B
AW, 38, signed width of accumulator and ANS; must satisfy AW >= 2*DW+1 (elaboration-time check)
SAT, 1, 1 = saturate MAC result to AW signed range; 0 = two's-complement wrap

Ports:
CLK  in  1  clock, rising edge
RESETN  in  1  asynchronous active-low reset
IN_VALID  in  1  operands and MODE valid this cycle
A  in  DW  signed operand (sample)
B  in  DW  signed operand (coefficient)
MODE  in  2  operation select: 00 MUL, 01 ADD, 10 MAC, 11 LOAD
OUT_VALID  out  1  ANS carries a new result this cycle
ANS  out  AW  signed result
ACC  out  AW  current accumulator value (debug/readback)
OVF  out  1  sticky accumulator overflow flag

Behaviour:
- Reset (RESETN=0, asynchronous): ANS=0, ACC=0, OUT_VALID=0, OVF=0; both pipeline stage valids cleared. Reset mid-operation discards all in-flight operations; no OUT_VALID for them after release.
- Latency is fixed at 2 cycles: an input accepted at edge N (IN_VALID=1) produces OUT_VALID=1 at edge N+2. Throughput is 1 op/cycle; no stalls and no back-pressure.
- Stage 1 (registered at edge N): p1 = A*B (2*DW signed); s1 = sext(A)+sext(B) to AW; mode1 and v1 are registered alongside. Stage-1 registers load only when IN_VALID=1, so v1 follows IN_VALID.
- Stage 2 (registered at edge N+1, visible N+2), applied only when v1=1:
  - MUL: ANS = sext(p1); ACC unchanged.
  - ADD: ANS = s1; ACC unchanged.
  - MAC: sum = ACC + sext(p1), computed at AW+1 bits. If sum exceeds the AW signed range: with SAT=1 the result clamps to +2^(AW-1)-1 or -2^(AW-1) and OVF is set; with SAT=0 the result wraps and OVF is still set. ACC = ANS = result.
  - LOAD: ACC = ANS = sext(p1); OVF cleared. This starts a new tap sequence.
- When v1=0: OUT_VALID=0, and ANS, ACC and OVF hold their values.
- Back-to-back MAC ops accumulate every cycle with no bubble; the accumulator loop is entirely in stage 2.
- A LOAD immediately followed by MAC: the MAC accumulates onto the loaded value.
- MUL/ADD interleaved between MACs do not disturb ACC or OVF.
- Widths: all arithmetic is signed. The product never overflows AW because AW >= 2*DW+1, and ADD never overflows.
- MODE is sampled only with IN_VALID=1. X on A/B/MODE while IN_VALID=0 must not propagate to the outputs.

Decomposition:
- Package fir_pkg: MODE encodings as named constants (MODE_MUL=2'b00, MODE_ADD=2'b01, MODE_MAC=2'b10, MODE_LOAD=2'b11), plus the default DW/AW values shared with the filter top.
- One natural sub-module, sat_add: an AW-bit signed adder with overflow detect and optional clamp (SAT parameter), used in stage 2.

Test Plan:
- Reset: assert RESETN=0 asynchronously mid-stream, with ops in both stages -> ANS=0, ACC=0, OVF=0, OUT_VALID=0 immediately; no OUT_VALID in the 2 cycles after release.
- MUL/ADD: A=-3, B=7, MUL at edge N -> ANS=-21, OUT_VALID at N+2. Then A=32767, B=32767, ADD -> ANS=65534. ACC stays 0 throughout.
- MAC sequence: LOAD(2,3), then MAC(4,5), MAC(-1,6) on consecutive cycles -> ANS=6, 26, 20 on consecutive cycles; final ACC=20; OVF=0.
- Saturation: SAT=1, DW=16, AW=33; LOAD(-32768,-32768) then MAC(-32768,-32768) three times -> ACC clamps to 2^32-1 and OVF=1. A following LOAD(1,1) -> ACC=1, OVF=0. Repeat with SAT=0 -> ACC wraps, OVF=1.
- Valid gaps: IN_VALID pattern 1,0,1 with MAC(1,1) each -> OUT_VALID pattern 1,0,1 at +2; ACC goes 1, hold, 2 (from 0); ANS holds during the gap.
- Interleave: LOAD(10,1), MUL(2,2), MAC(1,1) -> ANS=10, 4, 11; ACC=11.
